// File: rtl/soc_uart_pkg.sv
// Shared types and constants for the SoC UART blocks.
package soc_uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

  // 10 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  // Default depth of the receive byte buffer.
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // 8N1 framing: eight data bits per frame.
  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/soc_sync_fifo.sv
// Single-clock circular FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; otherwise it is ignored and the contents stay untouched.
// The head word reads as zero while the FIFO is empty.
module soc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/soc_uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, frame FSM with a
// bit-period divider, and a small byte FIFO drained by valid/ready.
// Framing errors and dropped bytes are reported as single-cycle pulses.
module soc_uart_rx
  import soc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e state;
  logic             sync_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             tick;
  logic             stop_tick;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= rx_i;
      rx_s      <= sync_meta;
    end
  end

  // Sample strobe: half a bit into the start bit, then every full bit period.
  always_comb begin
    tick = 1'b0;
    case (state)
      START:      tick = (div == HALF_LAST);
      DATA, STOP: tick = (div == BIT_LAST);
      default:    tick = 1'b0;
    endcase
  end

  assign stop_tick = ena & (state == STOP) & tick;
  assign push      = stop_tick & rx_s;
  assign pop       = rx_valid_o & rx_ready_i;

  // Frame FSM; a low enable abandons any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (!ena) begin
        state   <= IDLE;
        div     <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            div     <= '0;
            bit_cnt <= '0;
            if (!rx_s) begin
              state <= START;
            end
          end
          START: begin
            if (tick) begin
              div   <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              div <= div + DIV_W'(1);
            end
          end
          DATA: begin
            if (tick) begin
              div   <= '0;
              shift <= {rx_s, shift[7:1]};
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              div <= div + DIV_W'(1);
            end
          end
          STOP: begin
            if (tick) begin
              div     <= '0;
              bit_cnt <= '0;
              state   <= IDLE;
              if (!rx_s) begin
                frame_err_o <= 1'b1;
              end
            end else begin
              div <= div + DIV_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            div   <= '0;
          end
        endcase
      end
    end
  end

  // Flag a good byte that the FIFO could not take this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= push & full & ~pop;
    end
  end

  soc_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(shift),
    .pop      (pop),
    .pop_data (rx_data_o),
    .full     (full),
    .empty    (empty)
  );

  assign rx_valid_o = ~empty;

endmodule

// File: tb/tb_soc_uart_rx.sv
// Self-checking bench for soc_uart_rx with a frame-level reference model.
module tb_soc_uart_rx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  logic [7:0] exp_q[$];
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int obs_ferr = 0;
  int obs_ovr  = 0;
  int checks   = 0;
  int passes   = 0;

  soc_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end else begin
      passes++;
    end
  endtask

  // Count pulse cycles and check every popped byte against the model queue.
  always @(negedge clk) begin
    if (frame_err_o) obs_ferr++;
    if (overrun_o) obs_ovr++;
    if (rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        checkOutput("pop_extra", 32'd1, 32'd0);
      end else begin
        checkOutput("pop_data", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: good frames are kept if there is room, else dropped.
  task automatic modelFrame(input logic [7:0] data, input logic stop);
    if (!stop) exp_ferr++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else exp_ovr++;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop);
    modelFrame(data, stop);
    rx_i = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      waitCycles(CPB);
    end
    rx_i = stop;
    waitCycles(CPB);
    rx_i = 1'b1;
  endtask

  task automatic partialFrame(input logic [7:0] data, input int nbits);
    rx_i = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < nbits; i++) begin
      rx_i = data[i];
      waitCycles(CPB);
    end
  endtask

  task automatic drainFifo(input bit random_ready);
    int n;
    n = 0;
    while (rx_valid_o && n < 200) begin
      rx_ready_i = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      waitCycles(1);
      n++;
    end
    rx_ready_i = 1'b0;
    checkOutput("drain_timeout", {31'd0, n < 200}, 32'd1);
    checkOutput("drain_left", exp_q.size(), 32'd0);
  endtask

  task automatic checkPulses(input string tag);
    checkOutput({tag, "_ferr"}, obs_ferr, exp_ferr);
    checkOutput({tag, "_ovr"}, obs_ovr, exp_ovr);
  endtask

  // Directed scenarios followed by randomized bursts.
  initial begin
    logic [7:0] d;
    logic       s;
    int         nf;
    rst_n = 1'b0;
    ena = 1'b1;
    rx_i = 1'b1;
    rx_ready_i = 1'b0;
    waitCycles(5);
    rst_n = 1'b1;
    waitCycles(3);

    checkOutput("reset_valid", {31'd0, rx_valid_o}, 32'd0);
    checkOutput("reset_data", {24'd0, rx_data_o}, 32'd0);
    checkOutput("reset_ferr", {31'd0, frame_err_o}, 32'd0);
    checkOutput("reset_ovr", {31'd0, overrun_o}, 32'd0);

    applyStimulus(8'hA5, 1'b1);
    checkOutput("single_valid", {31'd0, rx_valid_o}, 32'd1);
    checkOutput("single_data", {24'd0, rx_data_o}, 32'hA5);
    rx_ready_i = 1'b1;
    waitCycles(1);
    rx_ready_i = 1'b0;
    checkOutput("single_popped", {31'd0, rx_valid_o}, 32'd0);
    checkOutput("single_left", exp_q.size(), 32'd0);

    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("b2b_head", {24'd0, rx_data_o}, 32'h00);
    checkPulses("b2b");
    drainFifo(1'b0);

    rx_i = 1'b0;
    waitCycles(3);
    rx_i = 1'b1;
    waitCycles(40);
    checkOutput("glitch_valid", {31'd0, rx_valid_o}, 32'd0);
    checkPulses("glitch");

    applyStimulus(8'h3C, 1'b0);
    waitCycles(2 * CPB);
    checkOutput("ferr_valid", {31'd0, rx_valid_o}, 32'd0);
    checkPulses("ferr");

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b1);
      checkPulses("overrun");
    end
    checkOutput("overrun_head", {24'd0, rx_data_o}, 32'h01);
    drainFifo(1'b0);

    applyStimulus(8'h11, 1'b1);
    partialFrame(8'h77, 3);
    rst_n = 1'b0;
    exp_q.delete();
    waitCycles(2);
    checkOutput("rstmid_valid", {31'd0, rx_valid_o}, 32'd0);
    checkOutput("rstmid_data", {24'd0, rx_data_o}, 32'd0);
    rx_i = 1'b1;
    rst_n = 1'b1;
    waitCycles(12 * CPB);
    checkOutput("rstmid_after", {31'd0, rx_valid_o}, 32'd0);
    checkPulses("rstmid");

    applyStimulus(8'h5A, 1'b1);
    partialFrame(8'h33, 4);
    ena = 1'b0;
    waitCycles(5);
    rx_i = 1'b1;
    waitCycles(3);
    ena = 1'b1;
    waitCycles(12 * CPB);
    checkOutput("ena_valid", {31'd0, rx_valid_o}, 32'd1);
    checkOutput("ena_data", {24'd0, rx_data_o}, 32'h5A);
    checkPulses("ena");
    drainFifo(1'b0);

    for (int b = 0; b < 6; b++) begin
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        d = 8'($urandom);
        s = ($urandom_range(0, 7) != 0);
        applyStimulus(d, s);
        if (!s) waitCycles(2 * CPB);
        else waitCycles($urandom_range(0, 20));
      end
      checkPulses("rand");
      checkOutput("rand_valid", {31'd0, rx_valid_o}, {31'd0, exp_q.size() != 0});
      checkOutput("rand_head", {24'd0, rx_data_o}, (exp_q.size() != 0) ? {24'd0, exp_q[0]} : 32'd0);
      drainFifo(1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/soc_uart_rx.md
# soc_uart_rx

UART receive front-end for the `tt_um_kmakise_soc` top level. It takes the raw serial line from a dedicated input pin, synchronises and deserialises 8N1 frames, and buffers the received bytes in a small FIFO. The SoC core drains that FIFO through a valid/ready handshake. The block sits directly between the `ui_in` pin and the core's peripheral bus, which is the path the cocotb bench drives.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 4: byte FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: system clock; everything is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: tile enable; while low, the receiver is held idle.
- `rx_i`  in  1: raw serial line, idle high, asynchronous to `clk`.
- `rx_data_o`  out  8: byte at the FIFO head.
- `rx_valid_o`  out  1: FIFO non-empty.
- `rx_ready_i`  in  1: consumer accepts the head byte when high and `rx_valid_o` is high.
- `frame_err_o`  out  1: one-cycle pulse when a frame's stop bit is sampled low.
- `overrun_o`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation

- **Input synchroniser:** two flops on `rx_i`, both reset to 1. All later logic uses only the synchronised line `rx_s`.
- **IDLE:** bit counter = 0, divider = 0. A cycle with `rx_s`=0 moves the FSM to START.
- **START:** count `CLKS_PER_BIT/2` cycles (floor), then sample `rx_s`.
  - Sample 1: false start; return to IDLE and emit no pulse.
  - Sample 0: go to DATA.
- **DATA:** every `CLKS_PER_BIT` cycles, sample one bit into the shift register, LSB first. Go to STOP after the 8th bit.
- **STOP:** after `CLKS_PER_BIT` cycles, sample the stop bit.
  - Sample 1: push the byte into the FIFO.
  - Sample 0: pulse `frame_err_o` and discard the byte.
  - Either way, return to IDLE in the same cycle, so the next start edge may already be recognised in the following cycle.
- **FIFO:** circular buffer with read and write pointers plus an occupancy count.
  - Push when full, no pop: drop the byte and pulse `overrun_o`. Existing contents are unchanged.
  - Push when full with a pop in the same cycle: both happen; the count is unchanged and there is no overrun.
  - Pop when empty: impossible, because the pop condition is `rx_valid_o & rx_ready_i`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **`ena` low:** the FSM is forced to IDLE and any partial frame is abandoned without error pulses. The FIFO keeps its contents and pops still operate.
- **Reset, including mid-frame:** FSM goes to IDLE; FIFO empty; all outputs 0; synchroniser flops to 1.

## Timing

- Synchroniser latency is 2 cycles from a `rx_i` edge to `rx_s`.
- Stop bit sampled in cycle T: the FIFO is written at the end of T and `rx_valid_o` is high in T+1. `frame_err_o` or `overrun_o` is high during T+1 only.
- `rx_data_o` is stable while `rx_valid_o` is high and no pop occurs. After a pop it updates on the next cycle.
- Pulses are never stretched; at most one pulse per frame.

## Structure

- **Package `soc_uart_pkg`:** the `uart_rx_state_e` enum (IDLE, START, DATA, STOP) and the default baud constant.
- **Sub-module `soc_sync_fifo`:** parameterised width and depth, with push/pop/full/empty. The transmit path will reuse it later.
- The FSM, divider and synchroniser stay in `soc_uart_rx`.

## Test plan

All scenarios use `CLKS_PER_BIT`=8 and `FIFO_DEPTH`=4.

- **Single byte:** send 0xA5 with `rx_ready_i`=0 → `rx_valid_o` rises 1 cycle after the stop sample and `rx_data_o`=0xA5. Pulse `rx_ready_i` for one cycle → `rx_valid_o` drops.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → both bytes are read in order and `frame_err_o` never pulses.
- **Glitch rejection:** drive `rx_i` low for 3 cycles, then high → FSM returns to IDLE and there are no valid, error or overrun pulses.
- **Framing error:** send 0x3C with stop bit 0 → `frame_err_o` pulses exactly one cycle and the FIFO stays empty.
- **Overrun:** send 5 bytes (0x01 to 0x05) with `rx_ready_i`=0 → `overrun_o` pulses on the 5th byte. Then drain → 0x01 to 0x04 come out in order.
- **Reset and `ena` mid-frame:**
  - Assert `rst_n`=0 during DATA → outputs are 0 and the FIFO is empty, with no pulses.
  - Drop `ena` during DATA with one byte stored → the byte is retained and the partial frame is discarded.
